traffic_ctrl_multi: RTL and testbench

Parametrised multi-direction traffic-light controller: successor to the single-approach fixed-cycle light sequencer. It serves NUM_DIR approaches in round-robin with per-approach demand inputs, a minimum/maximum green window with gap extension, fixed yellow and all-red clearance, and a flashing-yellow override mode. All durations are in "seconds", derived from an internal prescaler of TICK_DIV clock cycles. It sits between the debounced detector/maintenance inputs and the lamp driver outputs.

---
 rtl/traffic_ctrl_multi.sv | 148 ++++++++++++++
 tb/tb_traffic_ctrl_multi.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_multi.sv
// Multi-approach traffic-light controller: round-robin service with demand
// inputs, min/max green with gap-out, fixed yellow and all-red, flash override.
module traffic_ctrl_multi #(
  parameter int unsigned NUM_DIR   = 2,
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 30,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned RED_CLR   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DIR-1:0]         req,
  input  logic                       flash,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [2:0]                 phase
);

  localparam int unsigned DW = $clog2(NUM_DIR);
  localparam int unsigned SW = DW + 1;
  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] L_PMAX  = PW'(TICK_DIV - 1);
  localparam logic [7:0]    L_GMIN  = 8'(GREEN_MIN);
  localparam logic [7:0]    L_GMAX  = 8'(GREEN_MAX);
  localparam logic [7:0]    L_YEL   = 8'(YELLOW_T);
  localparam logic [7:0]    L_RCLR  = 8'(RED_CLR);
  localparam logic [SW-1:0] L_NDIR  = SW'(NUM_DIR);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALL_RED = 3'd1,
    S_GREEN   = 3'd2,
    S_YELLOW  = 3'd3,
    S_FLASH   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_presc;
  logic [7:0]      r_ticks;
  logic [DW-1:0]   r_cur_dir;
  logic            r_flash_on;

  logic            w_tick;
  logic [7:0]      w_k;
  logic [NUM_DIR-1:0]   w_cur_oh;
  logic            w_other;
  logic [2*NUM_DIR-1:0] w_req2;
  logic [NUM_DIR-1:0]   w_rot;
  logic [NUM_DIR-1:0]   w_scan;
  logic            w_found;
  logic [DW-1:0]   w_off;
  logic [SW-1:0]   w_sum;
  logic [DW-1:0]   w_grant;

  assign w_tick   = (r_presc == L_PMAX);
  assign w_k      = r_ticks + 8'd1;
  assign w_cur_oh = NUM_DIR'(1) << r_cur_dir;
  assign w_other  = |(req & ~w_cur_oh);
  assign w_req2   = {req, req};
  // Bit j of w_rot is the demand of approach (cur_dir+1+j) mod NUM_DIR.
  assign w_rot    = NUM_DIR'(w_req2 >> (32'(r_cur_dir) + 32'd1));

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    w_scan  = w_rot;
    for (int unsigned j = 0; j < NUM_DIR; j++) begin
      if (!w_found && w_scan[0]) begin
        w_found = 1'b1;
        w_off   = DW'(j);
      end
      w_scan = w_scan >> 1;
    end
    w_sum   = {1'b0, r_cur_dir} + SW'(1) + {1'b0, w_off};
    w_grant = (w_sum >= L_NDIR) ? DW'(w_sum - L_NDIR) : DW'(w_sum);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = S_ALL_RED;
      S_ALL_RED: if (flash) w_next = S_FLASH;
                 else if (w_tick && w_k == L_RCLR) w_next = S_GREEN;
      S_GREEN:   if (flash) w_next = S_FLASH;
                 else if (w_tick && w_k >= L_GMIN && (w_other || w_k == L_GMAX))
                   w_next = S_YELLOW;
      S_YELLOW:  if (flash) w_next = S_FLASH;
                 else if (w_tick && w_k == L_YEL) w_next = S_ALL_RED;
      S_FLASH:   if (!flash) w_next = S_ALL_RED;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_ticks    <= '0;
      r_cur_dir  <= DW'(NUM_DIR - 1);
      r_flash_on <= 1'b0;
    end else begin
      if (w_next != r_state) begin
        r_presc <= '0;
        r_ticks <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick && r_state != S_FLASH) r_ticks <= w_k;
      end
      if (r_state == S_ALL_RED && w_next == S_GREEN) r_cur_dir <= w_grant;
      // Preloaded outside FLASH so the first flash period always starts lit.
      if (r_state != S_FLASH) r_flash_on <= 1'b1;
      else if (w_tick)        r_flash_on <= ~r_flash_on;
    end
  end

  always_comb begin
    red        = '0;
    yellow     = '0;
    green      = '0;
    active_dir = '0;
    phase      = r_state;
    case (r_state)
      S_ALL_RED: red = '1;
      S_GREEN: begin
        green      = w_cur_oh;
        red        = ~w_cur_oh;
        active_dir = r_cur_dir;
      end
      S_YELLOW: begin
        yellow     = w_cur_oh;
        red        = ~w_cur_oh;
        active_dir = r_cur_dir;
      end
      S_FLASH: yellow = {NUM_DIR{r_flash_on}};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: directed scenarios plus random demand/flash,
// checked every cycle against an elapsed-time reference model.
module tb_traffic_ctrl_multi;

  localparam int N    = 3;
  localparam int TD   = 4;
  localparam int GMIN = 2;
  localparam int GMAX = 4;
  localparam int YT   = 1;
  localparam int RC   = 1;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic       flash;
  logic [2:0] red, yellow, green;
  logic [1:0] active_dir;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase, served approach, cycles elapsed in the phase.
  int m_ph, m_dir, m_t;

  traffic_ctrl_multi #(
    .NUM_DIR(N), .TICK_DIV(TD), .GREEN_MIN(GMIN),
    .GREEN_MAX(GMAX), .YELLOW_T(YT), .RED_CLR(RC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .flash(flash),
    .red(red), .yellow(yellow), .green(green),
    .active_dir(active_dir), .phase(phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int grant_of(input int dir, input logic [2:0] rq);
    for (int i = 1; i <= N; i++) begin
      int d;
      d = (dir + i) % N;
      if (((rq >> d) & 3'b001) != 3'b000) return d;
    end
    return (dir + 1) % N;
  endfunction

  task automatic model_step();
    int  nxt, k;
    bit  tick;
    if (rst) begin
      m_ph = 0; m_dir = N - 1; m_t = 0;
    end else begin
      tick = ((m_t + 1) % TD) == 0;
      k    = (m_t + 1) / TD;
      nxt  = m_ph;
      case (m_ph)
        0: nxt = 1;
        1: if (flash) nxt = 4;
           else if (tick && k == RC) begin nxt = 2; m_dir = grant_of(m_dir, req); end
        2: if (flash) nxt = 4;
           else if (tick && k >= GMIN &&
                    (((req & ~(3'b001 << m_dir)) != 3'b000) || k == GMAX)) nxt = 3;
        3: if (flash) nxt = 4;
           else if (tick && k == YT) nxt = 1;
        4: if (!flash) nxt = 1;
        default: nxt = 0;
      endcase
      m_t  = (nxt == m_ph) ? m_t + 1 : 0;
      m_ph = nxt;
    end
  endtask

  function automatic logic [13:0] model_out();
    logic [2:0] r, y, g;
    logic [1:0] a;
    r = 3'b000; y = 3'b000; g = 3'b000; a = 2'd0;
    case (m_ph)
      1: r = 3'b111;
      2: begin g = 3'b001 << m_dir; r = ~g; a = 2'(m_dir); end
      3: begin y = 3'b001 << m_dir; r = ~y; a = 2'(m_dir); end
      4: y = (((m_t / TD) % 2) == 0) ? 3'b111 : 3'b000;
      default: ;
    endcase
    return {r, y, g, 3'(m_ph), a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s @%0t: observed=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outputs{r,y,g,ph,dir}", 32'({red, yellow, green, phase, active_dir}), 32'(model_out()));
    check("green_onehot", 32'($countones(green) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input logic [2:0] ph, input string tag);
    int n;
    n = 0;
    while (phase !== ph && n < 200) begin step(); n++; end
    check(tag, 32'(phase), 32'(ph));
  endtask

  initial begin
    int n;
    rst = 1'b1; req = 3'b000; flash = 1'b0;
    m_ph = 0; m_dir = N - 1; m_t = 0;
    run(2);
    check("reset_phase", 32'(phase), 32'd0);

    // Free-running rotation with no demand.
    rst = 1'b0;
    run(5);
    n = 0;
    while (green === 3'b001 && n < 40) begin n++; step(); end
    check("green_max_cycles", 32'(n), 32'd16);
    wait_phase(3'd2, "rot_to_green1");
    check("rot_dir1", 32'(active_dir), 32'd1);
    wait_phase(3'd3, "rot_yel1");
    wait_phase(3'd2, "rot_to_green2");
    check("rot_dir2", 32'(active_dir), 32'd2);
    wait_phase(3'd3, "rot_yel2");
    wait_phase(3'd2, "rot_to_green0");
    check("rot_dir0", 32'(active_dir), 32'd0);

    // Demand on dir 2 only from reset.
    rst = 1'b1; req = 3'b100; step();
    rst = 1'b0;
    wait_phase(3'd2, "req2_green");
    check("req2_first_grant", 32'(active_dir), 32'd2);
    n = 0;
    while (green === 3'b100 && n < 40) begin n++; step(); end
    check("req2_green_cycles", 32'(n), 32'd16);

    // Gap-out: req[1] rises in cycle 2 of dir-0 green.
    rst = 1'b1; req = 3'b000; step();
    rst = 1'b0;
    wait_phase(3'd2, "gap_green0");
    n = 0;
    while (green === 3'b001 && n < 40) begin
      n++;
      if (n == 2) req = 3'b010;
      step();
    end
    check("gap_green_cycles", 32'(n), 32'd8);
    check("gap_yellow", 32'(phase), 32'd3);
    wait_phase(3'd2, "gap_green1");
    check("gap_grant1", 32'(active_dir), 32'd1);

    // Skip idle dir 1 after dir 0 served.
    rst = 1'b1; req = 3'b000; step();
    rst = 1'b0;
    wait_phase(3'd3, "skip_yel0");
    req = 3'b101;
    wait_phase(3'd2, "skip_green");
    check("skip_grant2", 32'(active_dir), 32'd2);
    wait_phase(3'd3, "skip_yel2");
    wait_phase(3'd2, "skip_green_back");
    check("skip_grant0", 32'(active_dir), 32'd0);

    // Flash override mid-green, then resume after the interrupted approach.
    rst = 1'b1; req = 3'b000; step();
    rst = 1'b0;
    wait_phase(3'd2, "fl_green0");
    run(5);
    flash = 1'b1;
    step();
    check("fl_entry_yellow", 32'({red, yellow, green}), 32'({3'b000, 3'b111, 3'b000}));
    run(20);
    flash = 1'b0;
    step();
    check("fl_exit_allred", 32'(red), 32'd7);
    wait_phase(3'd2, "fl_resume");
    check("fl_resume_dir", 32'(active_dir), 32'd1);

    // Reset mid-yellow restarts at dir 0.
    wait_phase(3'd3, "rst_yel");
    rst = 1'b1; step();
    check("rst_mid_lamps", 32'({red, yellow, green, phase}), 32'd0);
    rst = 1'b0;
    wait_phase(3'd2, "rst_restart");
    check("rst_restart_dir", 32'(active_dir), 32'd0);

    // Reset and flash together: reset wins.
    rst = 1'b1; flash = 1'b1; step();
    check("rst_beats_flash", 32'(phase), 32'd0);
    rst = 1'b0; flash = 1'b0;

    // Random demand, occasional flash and reset.
    for (int c = 0; c < 400; c++) begin
      req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 30) == 0) flash = ~flash;
      rst = ($urandom_range(0, 150) == 0);
      step();
    end
    rst = 1'b0; flash = 1'b0; req = 3'b000;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
